// File: rtl/and32_bist.sv
// and32_bist: on-chip self-test engine for a 32-bit bitwise AND unit.
// Presents operand pairs (two fixed vectors, then LFSR-derived ones), holds
// each pair for a settle interval, samples the unit's result one cycle later
// and compares it against a locally computed a & b.
module and32_bist #(
    parameter int          NUM_VECTORS   = 256,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [31:0] SEED          = 32'hACE1_2345
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] dut_a,
    output logic [31:0] dut_b,
    input  logic [31:0] dut_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] first_fail_idx
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
    // An all-zero Galois LFSR never leaves zero, so a zero seed is remapped.
    localparam logic [31:0] SEED_EFF    = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [31:0] SWAP_MASK   = 32'h5A5A_5A5A;
    localparam logic [15:0] LAST_IDX    = 16'(NUM_VECTORS - 1);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    // Fixed directed vectors at the start of every run.
    localparam logic [31:0] VEC0_A = 32'd47;
    localparam logic [31:0] VEC0_B = 32'd25;
    localparam logic [31:0] VEC1_A = 32'h4222_0225;
    localparam logic [31:0] VEC1_B = 32'h4002_028A;

    logic [1:0]  state_reg;
    logic [15:0] idx_reg;
    logic [7:0]  settle_reg;
    logic [31:0] lfsr_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [15:0] err_reg;
    logic [15:0] ffi_reg;

    logic [31:0] lfsr_step;
    logic [31:0] lfsr_next;
    logic [31:0] next_a;
    logic [31:0] next_b;
    logic [15:0] idx_inc;
    logic        mismatch;

    // Next-vector generation and result comparison against the held operands.
    always_comb begin
        lfsr_step = {1'b0, lfsr_reg[31:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 32'd0);
        // The LFSR only moves once its state has been consumed by index >= 2,
        // so index 2 sees the seed itself.
        lfsr_next = (idx_reg >= 16'd2) ? lfsr_step : lfsr_reg;
        idx_inc   = idx_reg + 16'd1;
        if (idx_inc == 16'd1) begin
            next_a = VEC1_A;
            next_b = VEC1_B;
        end else begin
            next_a = lfsr_next;
            next_b = {lfsr_next[15:0], lfsr_next[31:16]} ^ SWAP_MASK;
        end
        mismatch = (dut_out != (a_reg & b_reg));
    end

    // Control sequencer: start, settle counting, check and result accumulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            idx_reg    <= 16'd0;
            settle_reg <= 8'd0;
            lfsr_reg   <= SEED_EFF;
            a_reg      <= 32'd0;
            b_reg      <= 32'd0;
            err_reg    <= 16'd0;
            ffi_reg    <= 16'hFFFF;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_reg  <= ST_DRIVE;
                        idx_reg    <= 16'd0;
                        settle_reg <= 8'd0;
                        lfsr_reg   <= SEED_EFF;
                        a_reg      <= VEC0_A;
                        b_reg      <= VEC0_B;
                        err_reg    <= 16'd0;
                        ffi_reg    <= 16'hFFFF;
                    end
                end
                ST_DRIVE: begin
                    if (settle_reg == SETTLE_LAST) begin
                        settle_reg <= 8'd0;
                        state_reg  <= ST_CHECK;
                    end else begin
                        settle_reg <= settle_reg + 8'd1;
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_reg != 16'hFFFF) begin
                            err_reg <= err_reg + 16'd1;
                        end
                        if (ffi_reg == 16'hFFFF) begin
                            ffi_reg <= idx_reg;
                        end
                    end
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= ST_DONE;
                    end else begin
                        idx_reg   <= idx_inc;
                        lfsr_reg  <= lfsr_next;
                        a_reg     <= next_a;
                        b_reg     <= next_b;
                        state_reg <= ST_DRIVE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign dut_a          = a_reg;
    assign dut_b          = b_reg;
    assign busy           = (state_reg == ST_DRIVE) || (state_reg == ST_CHECK);
    assign done           = (state_reg == ST_DONE);
    assign pass           = (state_reg == ST_DONE) && (err_reg == 16'd0);
    assign err_count      = err_reg;
    assign first_fail_idx = ffi_reg;

endmodule

// File: tb/tb_and32_bist.sv
// Self-checking bench for and32_bist: a small instance (4 vectors, settle 1)
// and a large one (256 vectors, settle 3), each wired to a behavioural
// unit-under-test whose fault mode the bench selects.
`timescale 1ns/1ps
module tb_and32_bist;

    localparam logic [31:0] SEED = 32'hACE1_2345;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        start [2];
    logic [31:0] dut_a [2];
    logic [31:0] dut_b [2];
    logic [31:0] dut_out [2];
    logic        busy [2];
    logic        done [2];
    logic        pass [2];
    logic [15:0] err_count [2];
    logic [15:0] first_fail_idx [2];

    int          mode [2];
    logic [31:0] key [2];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model results for the run about to be made.
    logic [31:0] exp_a [256];
    logic [31:0] exp_b [256];
    bit          exp_bad [256];
    int          exp_errs;
    logic [15:0] exp_ffi;

    and32_bist #(.NUM_VECTORS(4), .SETTLE_CYCLES(1), .SEED(SEED)) u_small (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]),
        .dut_a(dut_a[0]), .dut_b(dut_b[0]), .dut_out(dut_out[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(err_count[0]), .first_fail_idx(first_fail_idx[0])
    );

    and32_bist #(.NUM_VECTORS(256), .SETTLE_CYCLES(3), .SEED(SEED)) u_big (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]),
        .dut_a(dut_a[1]), .dut_b(dut_b[1]), .dut_out(dut_out[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(err_count[1]), .first_fail_idx(first_fail_idx[1])
    );

    // Behavioural unit-under-test: 0 correct, 1 bit 9 stuck at 0, 2 OR, 3 keyed fault.
    function automatic logic [31:0] uut_f(input int m, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] k);
        case (m)
            1:       return (a & b) & ~32'h0000_0200;
            2:       return a | b;
            3:       return (a & b) ^ ((((a ^ k) & 32'h7) == 32'd0) ? 32'h0000_0100 : 32'd0);
            default: return a & b;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++) dut_out[i] = uut_f(mode[i], dut_a[i], dut_b[i], key[i]);
    end

    function automatic int nv(input int u);
        return (u == 0) ? 4 : 256;
    endfunction

    function automatic int sc(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    // Vector list and expected outcome straight from the vector rules.
    task automatic build_model(input int u);
        logic [31:0] s;
        s        = SEED;
        exp_errs = 0;
        exp_ffi  = 16'hFFFF;
        for (int k = 0; k < nv(u); k++) begin
            if (k == 0) begin
                exp_a[k] = 32'd47;
                exp_b[k] = 32'd25;
            end else if (k == 1) begin
                exp_a[k] = 32'h4222_0225;
                exp_b[k] = 32'h4002_028A;
            end else begin
                exp_a[k] = s;
                exp_b[k] = {s[15:0], s[31:16]} ^ 32'h5A5A_5A5A;
                s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'd0);
            end
            exp_bad[k] = (uut_f(mode[u], exp_a[k], exp_b[k], key[u]) !== (exp_a[k] & exp_b[k]));
            if (exp_bad[k]) begin
                exp_errs++;
                if (exp_ffi == 16'hFFFF) exp_ffi = 16'(k);
            end
        end
    endtask

    // One full run from start to done with optional stray start pulses.
    task automatic do_run(input int u, input int n_extra, input string tag);
        int          total;
        int          per;
        int          extra_at [$];
        bit          ops_ok;
        bit          flags_ok;
        int          bad_c;
        logic [31:0] sd;
        logic [31:0] sd_b;
        bit          hit;
        total    = nv(u) * (sc(u) + 1);
        per      = sc(u) + 1;
        ops_ok   = 1'b1;
        flags_ok = 1'b1;
        bad_c    = -1;
        sd       = SEED;
        sd_b     = {sd[15:0], sd[31:16]} ^ 32'h5A5A_5A5A;
        build_model(u);
        for (int i = 0; i < n_extra; i++) extra_at.push_back($urandom_range(total - 2, 1));

        start[u] = 1'b1;
        @(posedge clk);
        #1;
        start[u] = 1'b0;
        n_checks++;
        if (done[u] !== 1'b0) $display("FAIL %s start_done got %0b want 0", tag, done[u]);
        else n_pass++;
        n_checks++;
        if (err_count[u] !== 16'd0) $display("FAIL %s start_err got %0d want 0", tag, err_count[u]);
        else n_pass++;
        n_checks++;
        if (first_fail_idx[u] !== 16'hFFFF) $display("FAIL %s start_ffi got %h want ffff", tag, first_fail_idx[u]);
        else n_pass++;

        for (int c = 0; c < total; c++) begin
            if ((dut_a[u] !== exp_a[c / per]) || (dut_b[u] !== exp_b[c / per])) begin
                if (ops_ok) bad_c = c;
                ops_ok = 1'b0;
            end
            if ((busy[u] !== 1'b1) || (done[u] !== 1'b0)) flags_ok = 1'b0;
            if (c == 2 * per) begin
                n_checks++;
                if ((dut_a[u] !== sd) || (dut_b[u] !== sd_b))
                    $display("FAIL %s idx2_ops got %h/%h want %h/%h", tag, dut_a[u], dut_b[u], sd, sd_b);
                else n_pass++;
            end
            hit = 1'b0;
            foreach (extra_at[i]) if (extra_at[i] == c) hit = 1'b1;
            start[u] = hit;
            @(posedge clk);
            #1;
        end
        start[u] = 1'b0;

        n_checks++;
        if (!ops_ok) $display("FAIL %s operands cycle %0d got mismatch want model vector", tag, bad_c);
        else n_pass++;
        n_checks++;
        if (!flags_ok) $display("FAIL %s busy_done_during_run got wrong want busy=1 done=0", tag);
        else n_pass++;
        n_checks++;
        if ((done[u] !== 1'b1) || (busy[u] !== 1'b0))
            $display("FAIL %s end_flags got done=%0b busy=%0b want 1/0", tag, done[u], busy[u]);
        else n_pass++;
        n_checks++;
        if (err_count[u] !== 16'(exp_errs)) $display("FAIL %s err_count got %0d want %0d", tag, err_count[u], exp_errs);
        else n_pass++;
        n_checks++;
        if (first_fail_idx[u] !== exp_ffi) $display("FAIL %s first_fail_idx got %h want %h", tag, first_fail_idx[u], exp_ffi);
        else n_pass++;
        n_checks++;
        if (pass[u] !== (exp_errs == 0)) $display("FAIL %s pass got %0b want %0b", tag, pass[u], exp_errs == 0);
        else n_pass++;

        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ((done[u] !== 1'b1) || (dut_a[u] !== exp_a[nv(u) - 1]) || (dut_b[u] !== exp_b[nv(u) - 1]))
            $display("FAIL %s done_hold got done=%0b a=%h want 1 a=%h", tag, done[u], dut_a[u], exp_a[nv(u) - 1]);
        else n_pass++;
        $display("run %s: unit %0d mode %0d vectors %0d errs %0d first_fail %h pass %0b",
                 tag, u, mode[u], nv(u), err_count[u], first_fail_idx[u], pass[u]);
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0;
            start[u] = 1'b0;
            mode[u]  = 0;
            key[u]   = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if ((busy[u] !== 1'b0) || (done[u] !== 1'b0) || (pass[u] !== 1'b0))
                $display("FAIL reset_flags u%0d got %0b%0b%0b want 000", u, busy[u], done[u], pass[u]);
            else n_pass++;
            n_checks++;
            if ((err_count[u] !== 16'd0) || (first_fail_idx[u] !== 16'hFFFF))
                $display("FAIL reset_counts u%0d got %h/%h want 0000/ffff", u, err_count[u], first_fail_idx[u]);
            else n_pass++;
            n_checks++;
            if ((dut_a[u] !== 32'd0) || (dut_b[u] !== 32'd0))
                $display("FAIL reset_ops u%0d got %h/%h want 0/0", u, dut_a[u], dut_b[u]);
            else n_pass++;
        end
        // Start together with reset must be ignored.
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        n_checks++;
        if ((busy[0] !== 1'b0) || (dut_a[0] !== 32'd0))
            $display("FAIL reset_beats_start got busy=%0b a=%h want 0/0", busy[0], dut_a[0]);
        else n_pass++;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(posedge clk);
        #1;
        $display("reset: checked both instances");
    endtask

    task automatic test_mid_reset();
        int pre_errs;
        mode[0] = 2;
        build_model(0);
        pre_errs = int'(exp_bad[0]) + int'(exp_bad[1]);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if ((err_count[0] !== 16'(pre_errs)) || (busy[0] !== 1'b1))
            $display("FAIL midrst_pre got err=%0d busy=%0b want %0d/1", err_count[0], busy[0], pre_errs);
        else n_pass++;
        rst_n[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        n_checks++;
        if ((busy[0] !== 1'b0) || (done[0] !== 1'b0) || (err_count[0] !== 16'd0) ||
            (first_fail_idx[0] !== 16'hFFFF) || (dut_a[0] !== 32'd0) || (dut_b[0] !== 32'd0))
            $display("FAIL midrst_post got busy=%0b done=%0b err=%0d ffi=%h a=%h want 0 0 0 ffff 0",
                     busy[0], done[0], err_count[0], first_fail_idx[0], dut_a[0]);
        else n_pass++;
        $display("mid-run reset: err before reset %0d", pre_errs);
        @(posedge clk);
        #1;
        mode[0] = 0;
        do_run(0, 0, "after_reset");
    endtask

    task automatic test_correct();
        mode[0] = 0;
        do_run(0, 0, "correct");
    endtask

    task automatic test_stuck_bit9();
        mode[0] = 1;
        do_run(0, 0, "stuck_bit9");
        n_checks++;
        if (first_fail_idx[0] !== 16'd1) $display("FAIL stuck_bit9_ffi got %h want 0001", first_fail_idx[0]);
        else n_pass++;
    endtask

    task automatic test_or_unit();
        mode[0] = 2;
        do_run(0, 0, "or_unit");
        n_checks++;
        if (first_fail_idx[0] !== 16'd0) $display("FAIL or_unit_ffi got %h want 0000", first_fail_idx[0]);
        else n_pass++;
    endtask

    task automatic test_start_while_busy();
        mode[0] = 0;
        do_run(0, 3, "start_busy");
        mode[0] = 2;
        do_run(0, 2, "start_busy_or");
    endtask

    task automatic test_random_faults();
        for (int i = 0; i < 6; i++) begin
            mode[0] = 3;
            key[0]  = $urandom;
            do_run(0, $urandom_range(2, 0), "random_small");
        end
        mode[1] = 3;
        key[1]  = $urandom;
        do_run(1, $urandom_range(3, 0), "random_big");
    endtask

    task automatic test_back_to_back();
        mode[1] = 1;
        do_run(1, 0, "big_stuck");
        mode[1] = 0;
        do_run(1, 2, "big_restart");
        mode[0] = 0;
        do_run(0, 0, "b2b_a");
        do_run(0, 0, "b2b_b");
    endtask

    initial begin
        test_reset();
        test_correct();
        test_stuck_bit9();
        test_or_unit();
        test_mid_reset();
        test_start_while_busy();
        test_random_faults();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/and32_bist.md
# and32_bist

Built-in self-test engine for the 32-bit bitwise AND unit. It drives operand pairs onto an external unit-under-test, waits a settle interval, then samples the unit's output and compares it against an internally computed golden `a & b`. It accumulates a mismatch count and reports pass/fail. It is the hardware counterpart of the software stimulus benches: the vectors are generated and checked on-chip, so the ALU datapath can be self-tested after integration.

## Interface
- `NUM_VECTORS`, 256: total vectors per run. Legal range is 2..65535.
- `SETTLE_CYCLES`, 1: cycles each vector is held before sampling. Legal range is 1..255.
- `SEED`, 32'hACE1_2345: LFSR load value. A value of 0 is replaced by 32'h0000_0001.

Ports:
- `clk`, input, 1: the single clock. Everything is rising-edge.
- `rst_n`, input, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`, input, 1: one-cycle request to begin a run. Ignored unless in IDLE or DONE.
- `dut_a`, output, 32: operand A to the unit-under-test.
- `dut_b`, output, 32: operand B to the unit-under-test.
- `dut_out`, input, 32: result from the unit-under-test.
- `busy`, output, 1: high in DRIVE and CHECK.
- `done`, output, 1: high in DONE. Held until the next `start` or reset.
- `pass`, output, 1: valid only while `done` is high. Equals 1 iff `err_count` == 0.
- `err_count`, output, 16: number of mismatching vectors. Saturates at 16'hFFFF.
- `first_fail_idx`, output, 16: index of the first mismatching vector. Reads 16'hFFFF if no vector has failed.

## Operation
- **States:** IDLE, DRIVE, CHECK, DONE.
- **Reset values** (`rst_n` = 0 at a clock edge):
  - state = IDLE
  - `dut_a` = `dut_b` = 0
  - `busy` = `done` = `pass` = 0
  - `err_count` = 0
  - `first_fail_idx` = 16'hFFFF
  - vector index = 0, settle counter = 0
  - LFSR = SEED (or 1 if SEED is 0)
- **IDLE/DONE + `start`:** go to DRIVE. In the same edge:
  - clear `err_count`, set `first_fail_idx` = 16'hFFFF, clear `done`
  - index = 0, reload LFSR
  - present vector 0
- **Vector sequence:**
  - Index 0: `dut_a` = 32'd47, `dut_b` = 32'd25. Golden = 32'd9.
  - Index 1: `dut_a` = 32'h4222_0225, `dut_b` = 32'h4002_028A. Golden = 32'h4002_0200.
  - Index ≥ 2: `dut_a` = current LFSR state `s`, `dut_b` = {s[15:0], s[31:16]} ^ 32'h5A5A_5A5A.
- **LFSR:** 32-bit Galois shift-right, next = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 0). It advances exactly once after each CHECK of an index ≥ 2.
- **DRIVE:** hold `dut_a`/`dut_b` stable and count settle cycles. After SETTLE_CYCLES cycles in DRIVE, go to CHECK.
- **CHECK (one cycle):**
  - Compare `dut_out` with `dut_a & dut_b` (the registered operands).
  - On mismatch: `err_count` += 1 (saturating). If `first_fail_idx` is 16'hFFFF, load it with the current index.
  - If index == NUM_VECTORS−1, go to DONE. Otherwise index += 1, present the next vector, and go to DRIVE.
- **Operand stability:** `dut_a`/`dut_b` change only on the CHECK→DRIVE edge or the start edge. They hold their last value in DONE.
- **`start` while busy:** no effect.
- **`start` and reset in the same cycle:** reset wins.

## Timing
- Operands are registered outputs. Vector 0 appears on the edge that accepts `start`.
- Each vector occupies SETTLE_CYCLES cycles in DRIVE plus 1 cycle in CHECK.
- `done` rises exactly NUM_VECTORS × (SETTLE_CYCLES+1) cycles after the `start` edge.
- `dut_out` is sampled at the end of the CHECK cycle, after at least SETTLE_CYCLES+1 cycles of operand stability. The unit-under-test must be combinational or have latency ≤ SETTLE_CYCLES.
- `err_count` and `first_fail_idx` update on the CHECK edge. The final values are visible in the same cycle that `done` rises.
- A mid-run reset aborts the run immediately: all outputs return to their reset values on that edge, with no partial `done`.

## Test plan
1. **Correct AND unit, NUM_VECTORS=4, SETTLE_CYCLES=1:** pulse `start` → `done` goes high 8 cycles later, `err_count` = 0, `pass` = 1, `first_fail_idx` = 16'hFFFF.
2. **Unit with `dut_out` bit 9 stuck at 0:**
   - Index 0 passes (golden 9).
   - Index 1 fails (golden 32'h4002_0200).
   - Expect `first_fail_idx` = 1, `err_count` ≥ 1, `pass` = 0.
3. **Unit computing OR instead of AND:** index 0 returns 63 vs golden 9 → `first_fail_idx` = 0. With NUM_VECTORS=2, `err_count` = 2.
4. **Reset mid-run:** assert `rst_n` = 0 in the third DRIVE cycle → next edge shows IDLE, `busy` = 0, `err_count` = 0, `dut_a` = 0. A fresh `start` reproduces the scenario 1 results.
5. **`start` while busy:** extra `start` pulses mid-run → completion time and results are identical to scenario 1.
6. **Restart from DONE, SETTLE_CYCLES=3, NUM_VECTORS=256:**
   - After a failing run, pulse `start` with the correct unit → `done` drops, `err_count` clears on the start edge.
   - `done` returns high after 1024 cycles with `pass` = 1.
   - `dut_a`/`dut_b` for index 2 equal SEED and {SEED[15:0], SEED[31:16]} ^ 32'h5A5A_5A5A.
